// File: rtl/buzz_pkg.sv
// rtl/buzz_pkg.sv - shared state, source-code and priority definitions for buzzer_arbiter
package buzz_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALARM = 2'd1,
      S_CHIME = 2'd2,
      S_CLICK = 2'd3
   } state_e;

   localparam logic [1:0] SRC_IDLE  = 2'd0;
   localparam logic [1:0] SRC_ALARM = 2'd1;
   localparam logic [1:0] SRC_CHIME = 2'd2;
   localparam logic [1:0] SRC_CLICK = 2'd3;

   // Higher value preempts lower value.
   localparam logic [1:0] PRIO_IDLE  = 2'd0;
   localparam logic [1:0] PRIO_CLICK = 2'd1;
   localparam logic [1:0] PRIO_CHIME = 2'd2;
   localparam logic [1:0] PRIO_ALARM = 2'd3;

   localparam int SEC_W  = $clog2(63 + 1);
   localparam int CYC_W  = $clog2(1023 + 1);
   localparam int TONE_W = $clog2(255 + 1);

   function automatic logic [1:0] prio_of(state_e s);
      logic [1:0] p;
      p = PRIO_IDLE;
      case (s)
         S_ALARM: p = PRIO_ALARM;
         S_CHIME: p = PRIO_CHIME;
         S_CLICK: p = PRIO_CLICK;
         default: p = PRIO_IDLE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/buzzer_arbiter_if.sv
// rtl/buzzer_arbiter_if.sv - request/timing inputs and buzzer outputs between core and arbiter
interface buzzer_arbiter_if;

   logic       tick_1hz;
   logic       blink;
   logic       alarm_en;
   logic       set_mode;
   logic       alarm_req;
   logic       chime_req;
   logic       click_req;
   logic       cancel;
   logic       buzz;
   logic [1:0] src;
   logic       done;

   modport master (
      output tick_1hz, blink, alarm_en, set_mode,
      output alarm_req, chime_req, click_req, cancel,
      input  buzz, src, done
   );

   modport slave (
      input  tick_1hz, blink, alarm_en, set_mode,
      input  alarm_req, chime_req, click_req, cancel,
      output buzz, src, done
   );

endinterface

// File: rtl/buzzer_arbiter_tone_gen.sv
// rtl/buzzer_arbiter_tone_gen.sv - square-wave tone: phase counter with toggle at wrap
module tone_gen
   import buzz_pkg::*;
#(
   parameter int TONE_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic restart,
   output logic tone_q,
   output logic tone_nxt
);

   localparam logic [TONE_W-1:0] PHASE_LAST = TONE_W'(TONE_DIV - 1);

   logic [TONE_W-1:0] phase_q, phase_d;
   logic              tone_d;

   always_comb begin
      phase_d = phase_q;
      tone_d  = tone_q;
      if (restart) begin
         phase_d = '0;
         tone_d  = 1'b1;
      end else if (run) begin
         if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            tone_d  = ~tone_q;
         end else begin
            phase_d = phase_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
         tone_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         tone_q  <= tone_d;
      end
   end

   // Exposed so the registered buzz can use the same-edge tone value.
   assign tone_nxt = tone_d;

endmodule

// File: rtl/buzzer_arbiter.sv
// rtl/buzzer_arbiter.sv - fixed-priority preemptive buzzer sharing between alarm, chime, click and blink
module buzzer_arbiter
   import buzz_pkg::*;
#(
   parameter int TONE_DIV   = 4,
   parameter int ALARM_SECS = 30,
   parameter int CHIME_SECS = 2,
   parameter int CLICK_CYC  = 50
) (
   input logic               clk,
   input logic               rst,
   buzzer_arbiter_if.slave   bus
);

   localparam logic [SEC_W-1:0] ALARM_LAST = SEC_W'(ALARM_SECS - 1);
   localparam logic [SEC_W-1:0] CHIME_LAST = SEC_W'(CHIME_SECS - 1);
   localparam logic [CYC_W-1:0] CLICK_LAST = CYC_W'(CLICK_CYC - 1);

   state_e           state_q, state_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic             buzz_q, buzz_d;
   logic             done_q, done_d;
   logic             restart;
   logic             tone_run;
   logic             tone_q;
   logic             tone_nxt;
   logic             acc_alarm, acc_chime, acc_click;

   assign acc_alarm = bus.alarm_req && bus.alarm_en;
   assign acc_chime = bus.chime_req && !bus.set_mode && (prio_of(state_q) < PRIO_CHIME);
   assign acc_click = bus.click_req && (prio_of(state_q) < PRIO_CLICK);
   assign tone_run  = (state_q == S_ALARM) || (state_q == S_CHIME);

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      cyc_d   = cyc_q;
      done_d  = 1'b0;
      restart = 1'b0;
      buzz_d  = 1'b0;

      if (bus.cancel) begin
         state_d = S_IDLE;
         sec_d   = '0;
         cyc_d   = '0;
      end else if (acc_alarm) begin
         state_d = S_ALARM;
         sec_d   = '0;
         cyc_d   = '0;
         restart = 1'b1;
      end else if (state_q == S_ALARM && !bus.alarm_en) begin
         state_d = S_IDLE;
         sec_d   = '0;
      end else if (acc_chime) begin
         state_d = S_CHIME;
         sec_d   = '0;
         cyc_d   = '0;
         restart = 1'b1;
      end else if (acc_click) begin
         state_d = S_CLICK;
         cyc_d   = '0;
      end else begin
         case (state_q)
            S_ALARM, S_CHIME: begin
               if (bus.tick_1hz) begin
                  if (sec_q == ((state_q == S_ALARM) ? ALARM_LAST : CHIME_LAST)) begin
                     state_d = S_IDLE;
                     sec_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     sec_d = sec_q + 1'b1;
                  end
               end
            end
            S_CLICK: begin
               if (cyc_q == CLICK_LAST) begin
                  state_d = S_IDLE;
                  cyc_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cyc_d = cyc_q + 1'b1;
               end
            end
            default: ;
         endcase
      end

      case (state_d)
         S_ALARM: buzz_d = tone_nxt & bus.blink;
         S_CHIME: buzz_d = tone_nxt;
         S_CLICK: buzz_d = 1'b1;
         default: buzz_d = bus.set_mode ? bus.blink : 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sec_q   <= '0;
         cyc_q   <= '0;
         buzz_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         cyc_q   <= cyc_d;
         buzz_q  <= buzz_d;
         done_q  <= done_d;
      end
   end

   tone_gen #(
      .TONE_DIV (TONE_DIV)
   ) u_tone (
      .clk      (clk),
      .rst      (rst),
      .run      (tone_run),
      .restart  (restart),
      .tone_q   (tone_q),
      .tone_nxt (tone_nxt)
   );

   assign bus.buzz = buzz_q;
   assign bus.src  = state_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb/tb_buzzer_arbiter.sv - directed self-checking bench for buzzer_arbiter
module tb_buzzer_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   buzzer_arbiter_if bus ();

   buzzer_arbiter #(
      .TONE_DIV   (4),
      .ALARM_SECS (30),
      .CHIME_SECS (2),
      .CLICK_CYC  (50)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pulses();
      bus.tick_1hz  = 1'b0;
      bus.alarm_req = 1'b0;
      bus.chime_req = 1'b0;
      bus.click_req = 1'b0;
      bus.cancel    = 1'b0;
   endtask

   initial begin
      clear_pulses();
      bus.blink    = 1'b0;
      bus.alarm_en = 1'b0;
      bus.set_mode = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("reset_src", bus.src, 2'd0);
      chk("reset_buzz", bus.buzz, 1'b0);
      chk("reset_done", bus.done, 1'b0);

      // Chime: tone toggles every 4 cycles, ends on second tick.
      bus.chime_req = 1'b1;
      step();
      clear_pulses();
      chk("chime_enter_src", bus.src, 2'd2);
      chk("chime_enter_buzz", bus.buzz, 1'b1);
      for (int i = 1; i < 16; i++) begin
         step();
         chk("chime_tone", bus.buzz, ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
      end
      bus.tick_1hz = 1'b1;
      step();
      clear_pulses();
      chk("chime_tick1_src", bus.src, 2'd2);
      chk("chime_tick1_done", bus.done, 1'b0);
      step();
      bus.tick_1hz = 1'b1;
      step();
      clear_pulses();
      chk("chime_end_src", bus.src, 2'd0);
      chk("chime_end_done", bus.done, 1'b1);
      step();
      chk("chime_done_pulse", bus.done, 1'b0);

      // Click: 50 cycles of buzz=1, a second click mid-way is ignored.
      bus.click_req = 1'b1;
      step();
      clear_pulses();
      chk("click_enter", {bus.src, bus.buzz, bus.done}, {2'd3, 1'b1, 1'b0});
      for (int i = 1; i < 50; i++) begin
         bus.click_req = (i == 25);
         step();
         clear_pulses();
         chk("click_hold", {bus.src, bus.buzz, bus.done}, {2'd3, 1'b1, 1'b0});
      end
      step();
      chk("click_end", {bus.src, bus.buzz, bus.done}, {2'd0, 1'b0, 1'b1});
      step();
      chk("click_done_pulse", bus.done, 1'b0);

      // Click timeout coinciding with a chime request: chime wins, no done.
      bus.click_req = 1'b1;
      step();
      clear_pulses();
      for (int i = 1; i < 50; i++) step();
      chk("click_last_cycle", bus.src, 2'd3);
      bus.chime_req = 1'b1;
      step();
      clear_pulses();
      chk("timeout_vs_chime", {bus.src, bus.done}, {2'd2, 1'b0});
      bus.cancel = 1'b1;
      step();
      clear_pulses();
      chk("cancel_chime", {bus.src, bus.done}, {2'd0, 1'b0});

      // Alarm preempts chime; simultaneous click dropped.
      bus.chime_req = 1'b1;
      step();
      clear_pulses();
      step();
      bus.alarm_en  = 1'b1;
      bus.blink     = 1'b1;
      bus.alarm_req = 1'b1;
      bus.click_req = 1'b1;
      step();
      clear_pulses();
      chk("alarm_preempt", {bus.src, bus.buzz, bus.done}, {2'd1, 1'b1, 1'b0});
      for (int i = 1; i < 12; i++) begin
         bus.blink = (i != 2);
         step();
         chk("alarm_tone_blink", bus.buzz,
             ((i != 2) && ((i / 4) % 2 == 0)) ? 32'd1 : 32'd0);
      end
      bus.blink = 1'b1;
      bus.chime_req = 1'b1;
      step();
      clear_pulses();
      chk("chime_in_alarm", {bus.src, bus.done}, {2'd1, 1'b0});

      // Cancel beats a same-cycle alarm request.
      bus.cancel    = 1'b1;
      bus.alarm_req = 1'b1;
      step();
      clear_pulses();
      chk("cancel_vs_alarm", {bus.src, bus.done}, {2'd0, 1'b0});
      bus.alarm_req = 1'b1;
      step();
      clear_pulses();
      chk("alarm_reenter", bus.src, 2'd1);
      bus.alarm_en = 1'b0;
      step();
      chk("alarm_en_drop", {bus.src, bus.done}, {2'd0, 1'b0});
      bus.alarm_req = 1'b1;
      step();
      clear_pulses();
      chk("alarm_disabled_req", bus.src, 2'd0);
      bus.alarm_en = 1'b1;

      // Alarm duration restarts on re-entry; entry-cycle tick not counted.
      bus.alarm_req = 1'b1;
      step();
      clear_pulses();
      for (int i = 0; i < 20; i++) begin
         bus.tick_1hz = 1'b1;
         step();
         clear_pulses();
      end
      bus.alarm_req = 1'b1;
      bus.tick_1hz  = 1'b1;
      step();
      clear_pulses();
      for (int i = 0; i < 29; i++) begin
         bus.tick_1hz = 1'b1;
         step();
         clear_pulses();
      end
      chk("alarm_29_ticks", {bus.src, bus.done}, {2'd1, 1'b0});
      bus.tick_1hz = 1'b1;
      step();
      clear_pulses();
      chk("alarm_timeout", {bus.src, bus.done}, {2'd0, 1'b1});
      step();
      chk("alarm_done_pulse", bus.done, 1'b0);

      // Reset in the middle of an alarm.
      bus.alarm_req = 1'b1;
      step();
      clear_pulses();
      chk("alarm_pre_reset", bus.src, 2'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_reset", {bus.src, bus.buzz, bus.done}, {2'd0, 1'b0, 1'b0});
      bus.tick_1hz = 1'b1;
      step();
      clear_pulses();
      chk("post_reset_tick", {bus.src, bus.buzz, bus.done}, {2'd0, 1'b0, 1'b0});

      // Set mode: buzz follows blink one cycle late, chime blocked, click allowed.
      bus.blink    = 1'b0;
      bus.set_mode = 1'b1;
      step();
      chk("set_blink_low", bus.buzz, 1'b0);
      bus.blink = 1'b1;
      #1;
      chk("set_blink_delay", bus.buzz, 1'b0);
      step();
      chk("set_blink_high", bus.buzz, 1'b1);
      bus.blink = 1'b0;
      step();
      chk("set_blink_low2", bus.buzz, 1'b0);
      bus.chime_req = 1'b1;
      step();
      clear_pulses();
      chk("set_chime_ignored", bus.src, 2'd0);
      bus.click_req = 1'b1;
      step();
      clear_pulses();
      chk("set_click", {bus.src, bus.buzz}, {2'd3, 1'b1});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
- Shares the single buzzer output of the clock/alarm design between four sound sources: alarm ring, hourly chime, key click, and the set-mode blink indicator.
- Runs a fixed-priority, preemptive state machine with per-source duration counters.
- Gates a square-wave tone generator onto the buzzer pin.
- Sits between the timekeeping core (which supplies tick_1hz, blink, and the request pulses) and the board buzzer pin.

Parameters:
TONE_DIV, 4, clk cycles per tone half-period (range 1..255)
ALARM_SECS, 30, alarm ring duration in tick_1hz ticks (range 1..63)
CHIME_SECS, 2, chime duration in tick_1hz ticks (range 1..63)
CLICK_CYC, 50, key-click duration in clk cycles (range 1..1023)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
tick_1hz  in  1  one-cycle pulse, one per second
blink  in  1  0.5 Hz-duty blink level from the divider
alarm_en  in  1  level; alarm source enable
set_mode  in  1  level; clock is in edit mode
alarm_req  in  1  one-cycle pulse; alarm time matched
chime_req  in  1  one-cycle pulse; top of hour
click_req  in  1  one-cycle pulse; button accepted
cancel  in  1  one-cycle pulse; user silences the buzzer
buzz  out  1  registered buzzer drive
src  out  2  registered active source: 0 idle, 1 alarm, 2 chime, 3 click
done  out  1  one-cycle pulse; an activity ended by timeout

Behaviour:
- Reset values: state IDLE; buzz=0, src=0, done=0; tone phase 0; tone_q=0; all counters 0.
- States and priority: IDLE < CLICK < CHIME < ALARM. src encodes the state.
- Request acceptance (evaluated every cycle):
  - alarm_req with alarm_en=1 enters ALARM from any state, including re-entry from ALARM, which restarts the duration.
  - chime_req enters CHIME from IDLE or CLICK, only when set_mode=0. It is ignored in CHIME or ALARM.
  - click_req enters CLICK from IDLE only; it is ignored elsewhere.
  - Simultaneous requests: the highest priority wins; the others are dropped.
  - Preempted or dropped requests are never queued.
- Cancel: cancel=1 sends any non-IDLE state to IDLE next cycle. Cancel wins over every request in the same cycle, and done stays 0.
- alarm_en=0 while in ALARM forces IDLE next cycle, with done=0.
- Entry: on the entry edge the duration counter is cleared, the tone phase counter is cleared, and tone_q is set to 1.
- Durations:
  - ALARM and CHIME increment their counter on tick_1hz.
  - A tick arriving in the same cycle as the accepted request is not counted.
  - When tick_1hz=1 and counter==N-1, the next state is IDLE and done=1 for one cycle.
  - CLICK counts clk cycles: state exits after exactly CLICK_CYC cycles in CLICK, then done=1.
  - Timeout and a higher-priority request in the same cycle: the request wins, done=0.
- Tone: the phase counter runs 0..TONE_DIV-1 while in ALARM or CHIME. At wrap, tone_q toggles. Tone period is 2*TONE_DIV cycles.
- buzz and src are registered from the next-state value, so they change on the same edge as the state (latency 1 cycle from request).
- buzz value by next state:
  - ALARM: tone_q AND blink
  - CHIME: tone_q
  - CLICK: 1
  - IDLE: set_mode ? blink : 0
- Counter widths are sized by $clog2 of the parameter maximums. No wrap is possible because exit occurs at N-1.

Decomposition:
- Shared package buzz_pkg holds:
  - state enum (S_IDLE, S_ALARM, S_CHIME, S_CLICK)
  - 2-bit src code constants matching the state encoding
  - priority constant ordering
- One sub-module, tone_gen: a phase counter plus toggle with inputs run and restart, and output tone_q. It is instantiated once.

Test Plan:
1. Reset mid-ALARM with rst=1 for 1 cycle -> next cycle src=0, buzz=0, done=0. A subsequent tick_1hz produces no activity.
2. CHIME_SECS=2, set_mode=0, chime_req at cycle 10 -> src=2 at 11; buzz toggles every 4 cycles. Ticks at 20 and 30 -> src=0 at 31, done=1 only at 31.
3. click_req at cycle 5 -> src=3 and buzz=1 for cycles 6..55; src=0 and done=1 at 56. A second click_req at cycle 30 has no effect.
4. In CHIME, alarm_req with alarm_en=1 and click_req in the same cycle -> src=1 next cycle; buzz = tone_q & blink; chime never resumes and done stays 0.
5. In ALARM: cancel and alarm_req in the same cycle -> IDLE next cycle, done=0. Separately, dropping alarm_en -> IDLE next cycle.
6. set_mode=1 in IDLE -> buzz follows blink with 1-cycle delay. chime_req is ignored (src stays 0); click_req yields src=3.
